// File: rtl/tx_resp_arbiter.sv
// Round-robin response scheduler feeding the TX async FIFO write port, one byte per write.
// Optional backpressure watchdog enabled by defining TX_ARB_STALL_WDT_EN.
module tx_resp_arbiter #(
    parameter int D_WIDTH     = 8,
    parameter int STALL_LIMIT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rf_req_i,
    input  logic [D_WIDTH-1:0]     rf_data_i,
    output logic                   rf_ack_o,
    input  logic                   alu_req_i,
    input  logic [2*D_WIDTH-1:0]   alu_data_i,
    output logic                   alu_ack_o,
    input  logic                   fifo_full_i,
    output logic [D_WIDTH-1:0]     tx_p_data_o,
    output logic                   tx_d_vld_o,
    output logic                   busy_o,
    output logic                   tx_stall_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_B0   = 2'd1;
    localparam logic [1:0] ST_B1   = 2'd2;

    if (STALL_LIMIT < 1 || STALL_LIMIT > 65535) begin : g_bad_limit
        $error("STALL_LIMIT must be in 1..65535");
    end

    logic [1:0]           state_q, state_d;
    logic [2*D_WIDTH-1:0] hold_q, hold_d;
    logic                 is_alu_q, is_alu_d;
    logic                 last_alu_q, last_alu_d;
    logic                 rf_ack_q, rf_ack_d;
    logic                 alu_ack_q, alu_ack_d;
    logic [D_WIDTH-1:0]   data_q;
    logic                 sending;
    logic                 grant_rf, grant_alu;

    assign sending    = (state_q == ST_B0) || (state_q == ST_B1);
    assign tx_d_vld_o = sending && !fifo_full_i;
    assign busy_o     = (state_q != ST_IDLE);
    assign rf_ack_o   = rf_ack_q;
    assign alu_ack_o  = alu_ack_q;

    // On a tie the requester that did not win last time gets the grant.
    assign grant_rf  = (state_q == ST_IDLE) && rf_req_i && (!alu_req_i || last_alu_q);
    assign grant_alu = (state_q == ST_IDLE) && alu_req_i && !grant_rf;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        is_alu_d   = is_alu_q;
        last_alu_d = last_alu_q;
        rf_ack_d   = grant_rf;
        alu_ack_d  = grant_alu;
        case (state_q)
            ST_IDLE: begin
                if (grant_rf) begin
                    hold_d     = {{D_WIDTH{1'b0}}, rf_data_i};
                    is_alu_d   = 1'b0;
                    last_alu_d = 1'b0;
                    state_d    = ST_B0;
                end else if (grant_alu) begin
                    hold_d     = alu_data_i;
                    is_alu_d   = 1'b1;
                    last_alu_d = 1'b1;
                    state_d    = ST_B0;
                end
            end
            ST_B0: begin
                if (tx_d_vld_o) state_d = is_alu_q ? ST_B1 : ST_IDLE;
            end
            ST_B1: begin
                if (tx_d_vld_o) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_p_data_o = data_q;
        if (state_q == ST_B0)      tx_p_data_o = hold_q[D_WIDTH-1:0];
        else if (state_q == ST_B1) tx_p_data_o = hold_q[2*D_WIDTH-1:D_WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            is_alu_q   <= 1'b0;
            last_alu_q <= 1'b1;
            rf_ack_q   <= 1'b0;
            alu_ack_q  <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            is_alu_q   <= is_alu_d;
            last_alu_q <= last_alu_d;
            rf_ack_q   <= rf_ack_d;
            alu_ack_q  <= alu_ack_d;
            data_q     <= tx_p_data_o;
        end
    end

`ifdef TX_ARB_STALL_WDT_EN
    localparam logic [15:0] STALL_LIM = 16'(STALL_LIMIT);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_q, stall_d;

    // Any write or return to idle restarts the backpressure measurement.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (tx_d_vld_o || (state_d == ST_IDLE))
            stall_cnt_d = '0;
        else if (sending && fifo_full_i && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
        stall_d = tx_d_vld_o ? 1'b0 : (stall_q || (stall_cnt_d >= STALL_LIM));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign tx_stall_o = stall_q;
`else
    assign tx_stall_o = 1'b0;
`endif

endmodule

// File: doc/tx_resp_arbiter.md
# tx_resp_arbiter

Response scheduler between the system controller's response sources and the write port of the REF_CLK-domain TX async FIFO. It arbitrates between two requesters, round-robin on ties:
- register-file read responses (1 byte);
- ALU results (2 bytes, low byte first).

It serialises the captured response into single-byte FIFO writes and holds off while the FIFO reports full. A compile-time watchdog flags prolonged FIFO backpressure.

## Interface
Parameters:
- D_WIDTH, 8, byte width of FIFO data and RF response.
- STALL_LIMIT, 255, full-wait cycles before TX_STALL asserts (1..2^16-1).

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous, active-low reset.
- RF_REQ  in  1  RF response pending; held with RF_DATA until RF_ACK.
- RF_DATA  in  D_WIDTH  RF response byte.
- RF_ACK  out  1  one-cycle pulse: RF_DATA captured.
- ALU_REQ  in  1  ALU response pending; held with ALU_DATA until ALU_ACK.
- ALU_DATA  in  2*D_WIDTH  ALU result.
- ALU_ACK  out  1  one-cycle pulse: ALU_DATA captured.
- FIFO_FULL  in  1  FIFO write-side full flag.
- TX_P_DATA  out  D_WIDTH  byte to FIFO WR_DATA.
- TX_D_VLD  out  1  FIFO W_INC; one write per high cycle.
- BUSY  out  1  high whenever state != IDLE.
- TX_STALL  out  1  backpressure watchdog flag.

Reset values: RF_ACK=0, ALU_ACK=0, TX_D_VLD=0, TX_P_DATA=0, BUSY=0, TX_STALL=0. Internal state: state=IDLE, hold=0, last_grant=ALU, stall counter=0.

## Operation
- The FSM has three states: IDLE, SEND_B0 and SEND_B1. It also has a 2*D_WIDTH holding register and a 1-bit `is_alu` flag.
- **IDLE grant:**
  - Only RF_REQ high: capture {0, RF_DATA}, set is_alu=0, go to SEND_B0.
  - Only ALU_REQ high: capture ALU_DATA, set is_alu=1, go to SEND_B0.
  - Both high: grant the requester that is not last_grant. After reset, RF wins the first tie.
  - last_grant is updated on every grant.
- **ACK:** registered. It is high for exactly the cycle after the capture edge. The requester drops REQ at the next edge. REQ is ignored outside IDLE.
- **TX_D_VLD:** combinational, = (state==SEND_B0 or SEND_B1) and !FIFO_FULL. No write is ever issued while FIFO_FULL=1.
- **TX_P_DATA:** hold[D_WIDTH-1:0] in SEND_B0; hold[2*D_WIDTH-1:D_WIDTH] in SEND_B1; otherwise the last value.
- **SEND_B0 with a write:** go to SEND_B1 if is_alu, else IDLE.
- **SEND_B1 with a write:** go to IDLE.
- **Without a write:** stay in the current state. The held data is stable.
- **Width rule:** the ALU high byte is always sent, including when it is zero. RF responses are never extended.
- **Reset mid-operation:** the held response is discarded. No further bytes are written and no ACK follows.

## Timing
- Grant latency: REQ sampled at edge E1; ACK high in cycle E1..E2; first write possible in that same cycle.
- RF response: 1 write cycle, then IDLE. Minimum period is 2 cycles per RF response.
- ALU response: 2 consecutive write cycles if not full, then IDLE. Minimum period is 3 cycles.
- A FIFO_FULL stall extends the current state 1:1 with full cycles. The byte order is preserved.
- An RF_REQ arriving while BUSY is served in the first IDLE cycle.

## Configuration
- Macro: TX_ARB_STALL_WDT_EN.
- **Defined:**
  - A 16-bit counter increments on each cycle in SEND_B0/SEND_B1 with FIFO_FULL=1, saturating at 2^16-1.
  - When the counter reaches STALL_LIMIT, TX_STALL is set.
  - On any cycle with TX_D_VLD=1, the counter and TX_STALL are cleared at the next edge. The counter is also cleared on entering IDLE.
  - No data is dropped.
- **Undefined:** no counter is present and TX_STALL is tied to 0.

## Test plan
- Reset, FIFO_FULL=0, RF_REQ with RF_DATA=0x5A → RF_ACK one cycle; TX_D_VLD in that same cycle with TX_P_DATA=0x5A; BUSY low in the next cycle.
- ALU_REQ with ALU_DATA=0x12C4 → ALU_ACK; writes 0xC4 then 0x12 on consecutive cycles; exactly 2 W_INC pulses.
- RF_REQ and ALU_REQ both high after reset (RF_DATA=0x01, ALU_DATA=0xBEEF), then repeated simultaneous requests → write order 0x01, 0xEF, 0xBE, then alternating ALU-then-RF grants; no lost request.
- ALU_DATA=0xA55A, FIFO_FULL forced high for 10 cycles after the first byte → 0x5A written; 10 cycles with no write; then 0xA5; BUSY high throughout.
- With TX_ARB_STALL_WDT_EN and STALL_LIMIT=4, FIFO_FULL high for 6 cycles during SEND_B0 → TX_STALL rises after 4 full cycles; clears after the write once full drops. Without the macro, TX_STALL stays 0.
- RST asserted during an ALU SEND_B1 stall → all outputs immediately 0; after release, no stale 0xhigh byte is written and BUSY=0.
